lif_neuron_array_updater: RTL

- Parametrised, time-multiplexed successor to the single-neuron LIF potential adder.
- Holds membrane potentials for N_NEURONS neurons in an internal register file.
- Accumulates incoming synaptic weights one event per cycle.
- On each timestep-end request, sweeps all neurons (leak, threshold compare, reset, refractory) and streams spike IDs out.
- Sits between the spike/weight dispatcher and the spike router of the accelerator.

---
 rtl/lif_neuron_array_updater.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/lif_neuron_array_updater.sv
// -----------------------------------------------------------------------------
// lif_neuron_array_updater
//
// Time-multiplexed leaky integrate-and-fire update engine for N_NEURONS neurons.
// While idle it accumulates one synaptic weight event per cycle into the
// addressed neuron's membrane potential (saturating). A ts_end pulse starts a
// sweep that visits one neuron per cycle: refractory countdown, leak, threshold
// compare, reset and a registered spike pulse. The sweep ends with a one-cycle
// done pulse and the number of spikes emitted.
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   clear           zero all potentials and refractory counters (idle only)
//   cfg_threshold   signed firing threshold
//   cfg_reset_mode  0 = subtract threshold on fire, 1 = reset to zero
//   cfg_leak_shift  leak V -= V >>> shift (0 disables leak)
//   cfg_refract     refractory timesteps loaded after a spike
//   in_valid/in_ready/in_id/in_weight   weight event handshake
//   ts_end          request an end-of-timestep sweep
//   busy            sweep in progress
//   spike_valid/spike_id   one-cycle spike pulse and neuron index
//   done            one-cycle pulse at sweep completion
//   spike_count     spikes emitted in the last completed sweep
//   rd_id/rd_potential     combinational debug readback
// -----------------------------------------------------------------------------
module lif_neuron_array_updater #(
    parameter int N_NEURONS = 32,
    parameter int DATA_W    = 16,
    parameter int ID_W      = $clog2(N_NEURONS),
    parameter int REFR_W    = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] cfg_threshold,
    input  logic                     cfg_reset_mode,
    input  logic [3:0]               cfg_leak_shift,
    input  logic [REFR_W-1:0]        cfg_refract,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ID_W-1:0]          in_id,
    input  logic signed [DATA_W-1:0] in_weight,
    input  logic                     ts_end,
    output logic                     busy,
    output logic                     spike_valid,
    output logic [ID_W-1:0]          spike_id,
    output logic                     done,
    output logic [ID_W:0]            spike_count,
    input  logic [ID_W-1:0]          rd_id,
    output logic signed [DATA_W-1:0] rd_potential
);

    localparam int CNT_W = ID_W + 1;
    localparam logic [ID_W:0]      N_ID    = CNT_W'(N_NEURONS);
    localparam logic [ID_W-1:0]    LAST_ID = ID_W'(N_NEURONS - 1);
    localparam logic [DATA_W-1:0]  SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]  SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Clamp a one-bit-wider sum back to DATA_W; overflow shows up as the two
    // top bits disagreeing, and the top bit gives the direction.
    function automatic logic [DATA_W-1:0] sat_f(input logic [DATA_W:0] x);
        logic [DATA_W-1:0] r;
        if (x[DATA_W] != x[DATA_W-1]) begin
            r = x[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            r = x[DATA_W-1:0];
        end
        return r;
    endfunction

    state_t                     state_r;
    logic [ID_W-1:0]            idx_r;
    logic [CNT_W-1:0]           run_cnt_r;
    logic                       in_ready_r;
    logic                       busy_r;
    logic                       spike_valid_r;
    logic [ID_W-1:0]            spike_id_r;
    logic                       done_r;
    logic [CNT_W-1:0]           spike_count_r;
    logic signed [DATA_W-1:0]   v_mem_r [N_NEURONS];
    logic [REFR_W-1:0]          refr_r  [N_NEURONS];

    logic                       in_id_ok_s;
    logic                       ev_apply_s;
    logic [DATA_W:0]            ev_sum_s;
    logic signed [DATA_W-1:0]   cur_v_s;
    logic [REFR_W-1:0]          cur_refr_s;
    logic signed [DATA_W-1:0]   leak_amt_s;
    logic signed [DATA_W-1:0]   leak_v_s;
    logic [DATA_W:0]            sub_s;
    logic signed [DATA_W-1:0]   fire_v_s;
    logic                       fire_s;

    // Weight-event datapath: saturating add into the addressed neuron, gated
    // by its refractory counter.
    always_comb begin
        in_id_ok_s = ({1'b0, in_id} < N_ID);
        ev_sum_s   = {v_mem_r[in_id][DATA_W-1], v_mem_r[in_id]}
                   + {in_weight[DATA_W-1], in_weight};
        if (in_valid && in_ready_r && in_id_ok_s && (refr_r[in_id] == {REFR_W{1'b0}})) begin
            ev_apply_s = 1'b1;
        end else begin
            ev_apply_s = 1'b0;
        end
    end

    // Sweep datapath for the neuron at idx_r: leak, threshold compare and the
    // post-spike potential. L = V - (V >>> s) cannot overflow for s >= 1.
    always_comb begin
        cur_v_s    = v_mem_r[idx_r];
        cur_refr_s = refr_r[idx_r];
        if (cfg_leak_shift == 4'd0) begin
            leak_amt_s = {DATA_W{1'b0}};
        end else begin
            leak_amt_s = cur_v_s >>> cfg_leak_shift;
        end
        leak_v_s = cur_v_s - leak_amt_s;
        sub_s    = {leak_v_s[DATA_W-1], leak_v_s} - {cfg_threshold[DATA_W-1], cfg_threshold};
        if (cfg_reset_mode) begin
            fire_v_s = {DATA_W{1'b0}};
        end else begin
            fire_v_s = sat_f(sub_s);
        end
        if ((cur_refr_s == {REFR_W{1'b0}}) && (leak_v_s >= cfg_threshold)) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // Debug readback of the addressed potential; out-of-range indices read 0.
    always_comb begin
        if ({1'b0, rd_id} < N_ID) begin
            rd_potential = v_mem_r[rd_id];
        end else begin
            rd_potential = {DATA_W{1'b0}};
        end
    end

    // Control FSM, neuron state and all registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r       <= ST_IDLE;
            idx_r         <= {ID_W{1'b0}};
            run_cnt_r     <= {CNT_W{1'b0}};
            in_ready_r    <= 1'b1;
            busy_r        <= 1'b0;
            spike_valid_r <= 1'b0;
            spike_id_r    <= {ID_W{1'b0}};
            done_r        <= 1'b0;
            spike_count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem_r[i] <= {DATA_W{1'b0}};
                refr_r[i]  <= {REFR_W{1'b0}};
            end
        end else begin
            spike_valid_r <= 1'b0;
            done_r        <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // clear wins over a same-cycle event; a sweep started in
                    // the same cycle sees the cleared or updated state.
                    if (clear) begin
                        for (int i = 0; i < N_NEURONS; i++) begin
                            v_mem_r[i] <= {DATA_W{1'b0}};
                            refr_r[i]  <= {REFR_W{1'b0}};
                        end
                    end else if (ev_apply_s) begin
                        v_mem_r[in_id] <= sat_f(ev_sum_s);
                    end
                    if (ts_end) begin
                        state_r    <= ST_SWEEP;
                        idx_r      <= {ID_W{1'b0}};
                        run_cnt_r  <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (cur_refr_s != {REFR_W{1'b0}}) begin
                        refr_r[idx_r] <= cur_refr_s - {{(REFR_W-1){1'b0}}, 1'b1};
                    end else if (fire_s) begin
                        v_mem_r[idx_r] <= fire_v_s;
                        refr_r[idx_r]  <= cfg_refract;
                        spike_valid_r  <= 1'b1;
                        spike_id_r     <= idx_r;
                    end else begin
                        v_mem_r[idx_r] <= leak_v_s;
                    end
                    run_cnt_r <= run_cnt_r + CNT_W'(fire_s);
                    if (idx_r == LAST_ID) begin
                        // done and the final count land with the last
                        // neuron's spike pulse.
                        state_r       <= ST_FINISH;
                        busy_r        <= 1'b0;
                        done_r        <= 1'b1;
                        spike_count_r <= run_cnt_r + CNT_W'(fire_s);
                    end else begin
                        idx_r <= idx_r + {{(ID_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_FINISH: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign busy        = busy_r;
    assign spike_valid = spike_valid_r;
    assign spike_id    = spike_id_r;
    assign done        = done_r;
    assign spike_count = spike_count_r;

endmodule
